s_axil_register: RTL and testbench
==================================

Name: s_axil_register

Overview:
- AXI4-Lite slave register file: NUM_REG memory-mapped registers, each DATA_WIDTH wide, with byte-strobe writes and single-beat reads.
- Sits directly downstream of the AXI-Lite register master BFM and is the target it exercises.
- Accepts AW and W independently and in any order, returns one B per write and one R per read.
- At most one write and one read are outstanding at any time.

Parameters:
- S_AXI_DATA_WIDTH, 32: data width in bits; must be 32 or 64.
- S_AXI_ADDR_WIDTH, 32: address width in bits.
- NUM_REG, 16: number of registers; must be a power of 2 and ≥ 2.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-low reset.
- AWADDR  in  S_AXI_ADDR_WIDTH  write address.
- AWVALID  in  1 / AWREADY  out  1  write-address handshake.
- WDATA  in  S_AXI_DATA_WIDTH  write data.
- WSTRB  in  S_AXI_DATA_WIDTH/8  byte enables.
- WVALID  in  1 / WREADY  out  1  write-data handshake.
- BRESP  out  2  write response.
- BVALID  out  1 / BREADY  in  1  write-response handshake.
- ARADDR  in  S_AXI_ADDR_WIDTH  read address.
- ARVALID  in  1 / ARREADY  out  1  read-address handshake.
- RDATA  out  S_AXI_DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1 / RREADY  in  1  read-data handshake.

Behaviour:
- Reset (ARESET=0, asynchronous):
  - All registers = 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0.
  - Internal aw_full, w_full and rst_done = 0.
  - Any in-flight transaction is dropped with no response.
- rst_done: set at the first rising edge after reset release. All READYs are 0 until rst_done=1.
- Address decode:
  - ADDR_LSB = log2(S_AXI_DATA_WIDTH/8). Index = addr[ADDR_LSB +: log2(NUM_REG)]. Bits below ADDR_LSB are ignored.
  - In range: addr < NUM_REG*(S_AXI_DATA_WIDTH/8). Out of range gives SLVERR (2'b10); in range gives OKAY (2'b00).
- Write path, state flags aw_full, w_full, BVALID:
  - AWREADY = rst_done & !aw_full & !BVALID.
  - WREADY = rst_done & !w_full & !BVALID.
  - AW handshake (AWVALID&AWREADY at edge): latch AWADDR, set aw_full. W handshake likewise latches WDATA/WSTRB and sets w_full. Both may occur on the same edge or on different edges, in either order.
  - Commit, at the edge where aw_full & w_full & !BVALID:
    - If in range, reg[idx] byte k = WSTRB[k] ? WDATA byte k : old byte.
    - Out of range: no register changes.
    - Set BVALID and BRESP; clear aw_full and w_full.
  - Latency: last address/data handshake at edge N gives BVALID=1 after edge N+1.
  - BVALID and BRESP are held stable until the edge where BREADY=1, then BVALID=0. The next AW/W can be accepted in the cycle after that.
  - WSTRB=0: OKAY response, no register change.
- Read path:
  - ARREADY = rst_done & !RVALID.
  - On AR handshake at edge N: RDATA = reg[idx] (0 if out of range), RRESP set, RVALID=1 after edge N.
  - RDATA, RRESP and RVALID are held until the edge with RREADY=1; then RVALID=0, and RDATA keeps its last value.
  - Back-to-back reads: the next ARREADY rises in the cycle after the R handshake.
- Simultaneous read and write:
  - The read and write channels are fully independent.
  - An AR handshake on the same edge as a commit to the same register returns the pre-commit value.
  - A read accepted after the commit edge returns the new value.
- Reset asserted mid-operation (e.g. BVALID or RVALID pending, aw_full set): state clears immediately per the reset bullet. After release the block behaves as freshly reset.
- No combinational path from any VALID to any READY. All READYs derive only from registered state.

Test Plan:
- Write fill: write data i+1 to address 4*i for i=0..15, WSTRB=4'hF, randomly choosing AW with W / AW first / W first with 1–5 cycle gaps; then read back 0x00..0x3C → RDATA 1..16, all BRESP/RRESP = 2'b00, exactly one B per write.
- Byte strobes: reg0=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → read reg0 = 0x11BB33DD.
- W before AW: WVALID 3 cycles before AWVALID → WREADY low after the W handshake while AWREADY stays high; BVALID rises one cycle after the AW handshake edge.
- Backpressure:
  - Hold BREADY=0 for 5 cycles after BVALID → BVALID and BRESP stable, AWREADY=WREADY=0, and a second AW is not accepted until the cycle after the B handshake.
  - Hold RREADY=0 for 5 cycles → RDATA stable and ARREADY=0.
- Out of range: write 0xDEAD to 0x40 → BRESP=2'b10 and regs 0..15 unchanged; read 0x40 → RDATA=0, RRESP=2'b10.
- Reset mid-operation: drop ARESET while BVALID=1 and RVALID=1 → all outputs 0 asynchronously and reads after release return 0. READYs are 0 in the first cycle after release and 1 from the next edge onward.

Source files
------------

// File: rtl/s_axil_register.sv
// -----------------------------------------------------------------------------
// s_axil_register
//   AXI4-Lite slave exposing NUM_REG memory-mapped registers of
//   S_AXI_DATA_WIDTH bits each. Writes honour byte strobes; reads are
//   single-beat. AW and W are accepted independently, in either order, and
//   at most one write and one read are in flight at any time.
//
// Ports
//   ACLK                 clock, all logic on the rising edge
//   ARESET               asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WVALID/WREADY write data channel
//   BRESP/BVALID/BREADY  write response channel (OKAY or SLVERR)
//   ARADDR/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel
//
// Every READY is a function of registered state only, so there is no
// combinational path from any VALID to any READY.
// -----------------------------------------------------------------------------
module s_axil_register #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REG          = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY
);

  localparam int STRB_W   = S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REG);

  // First byte address past the register window, one bit wider than the
  // address so the compare cannot wrap.
  localparam logic [S_AXI_ADDR_WIDTH:0] ADDR_LIMIT =
    (S_AXI_ADDR_WIDTH+1)'(NUM_REG * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when a byte address falls inside the register window.
  function automatic logic addr_in_range(input logic [S_AXI_ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < ADDR_LIMIT);
  endfunction

  // Merge new data into an old word under a byte-enable mask.
  function automatic logic [S_AXI_DATA_WIDTH-1:0] apply_strobe(
    input logic [S_AXI_DATA_WIDTH-1:0] old_v,
    input logic [S_AXI_DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]           strb
  );
    logic [S_AXI_DATA_WIDTH-1:0] res;
    res = old_v;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Register storage and write/read channel state.
  logic [S_AXI_DATA_WIDTH-1:0] regs_r [NUM_REG];

  logic                        rst_done_r;
  logic                        aw_full_r;
  logic                        w_full_r;
  logic [S_AXI_ADDR_WIDTH-1:0] awaddr_r;
  logic [S_AXI_DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]           wstrb_r;
  logic                        bvalid_r;
  logic [1:0]                  bresp_r;
  logic                        rvalid_r;
  logic [1:0]                  rresp_r;
  logic [S_AXI_DATA_WIDTH-1:0] rdata_r;

  logic                        awready_s;
  logic                        wready_s;
  logic                        arready_s;
  logic                        aw_hs_s;
  logic                        w_hs_s;
  logic                        ar_hs_s;
  logic                        commit_s;
  logic                        waddr_ok_s;
  logic                        raddr_ok_s;
  logic [IDX_W-1:0]            widx_s;
  logic [IDX_W-1:0]            ridx_s;

  // A channel stops accepting while its slot is full or a response waits.
  assign awready_s = rst_done_r & ~aw_full_r & ~bvalid_r;
  assign wready_s  = rst_done_r & ~w_full_r  & ~bvalid_r;
  assign arready_s = rst_done_r & ~rvalid_r;

  assign aw_hs_s  = AWVALID & awready_s;
  assign w_hs_s   = WVALID  & wready_s;
  assign ar_hs_s  = ARVALID & arready_s;
  assign commit_s = aw_full_r & w_full_r & ~bvalid_r;

  assign widx_s     = awaddr_r[ADDR_LSB +: IDX_W];
  assign ridx_s     = ARADDR[ADDR_LSB +: IDX_W];
  assign waddr_ok_s = addr_in_range(awaddr_r);
  assign raddr_ok_s = addr_in_range(ARADDR);

  // Reset-done flag: holds every READY low for the first cycle after release.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // Write path: capture AW and W independently, commit once both are held.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      if (aw_hs_s) begin
        aw_full_r <= 1'b1;
        awaddr_r  <= AWADDR;
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        wdata_r  <= WDATA;
        wstrb_r  <= WSTRB;
      end
      // Handshakes and commit are mutually exclusive: a handshake needs its
      // slot empty, commit needs both slots full.
      if (commit_s) begin
        aw_full_r <= 1'b0;
        w_full_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= waddr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_r && BREADY) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Register array update on commit; out-of-range commits leave it untouched.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (commit_s && waddr_ok_s) begin
      regs_r[widx_s] <= apply_strobe(regs_r[widx_s], wdata_r, wstrb_r);
    end
  end

  // Read path: sample the array at the AR handshake. Because the array
  // updates with non-blocking assignment, a read on the commit edge returns
  // the pre-commit value. RDATA keeps its value after the R handshake.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      rvalid_r <= 1'b0;
      rresp_r  <= 2'b00;
      rdata_r  <= '0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rresp_r  <= raddr_ok_s ? RESP_OKAY : RESP_SLVERR;
      rdata_r  <= raddr_ok_s ? regs_r[ridx_s] : '0;
    end else if (rvalid_r && RREADY) begin
      rvalid_r <= 1'b0;
    end
  end

  assign AWREADY = awready_s;
  assign WREADY  = wready_s;
  assign ARREADY = arready_s;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;
  assign RVALID  = rvalid_r;
  assign RRESP   = rresp_r;
  assign RDATA   = rdata_r;

endmodule

// File: tb/tb_s_axil_register.sv
// -----------------------------------------------------------------------------
// tb_s_axil_register
//   Directed bench for s_axil_register (32-bit data, 16 registers). Inputs
//   change 1 ns after each rising edge; outputs are observed at that same
//   point, well away from the next edge. A small register model holds the
//   expected contents.
// -----------------------------------------------------------------------------
module tb_s_axil_register;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int          vec_cnt;
  int          miss_cnt;
  int          b_cnt;
  logic [31:0] exp_mem [16];
  logic [31:0] old_v;

  s_axil_register #(
    .S_AXI_DATA_WIDTH(32),
    .S_AXI_ADDR_WIDTH(32),
    .NUM_REG(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Count completed write responses.
  always @(posedge ACLK) begin
    if (ARESET && BVALID && BREADY) b_cnt <= b_cnt + 1;
  end

  // Overall time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input string tag);
    int cyc = 0;
    BREADY = 1'b1;
    while (!BVALID && cyc < 20) begin
      tick();
      cyc++;
    end
    check(tag, {61'd0, BVALID, BRESP}, {61'd0, 1'b1, exp_resp});
    tick();
    BREADY = 1'b0;
  endtask

  // One write: AW starts after aw_dly cycles, W after w_dly cycles.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] exp_resp, input string tag);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs;
    bit w_hs;
    int cyc = 0;
    AWADDR = addr;
    WDATA  = data;
    WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      aw_hs   = AWVALID && AWREADY;
      w_hs    = WVALID && WREADY;
      tick();
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check({tag, "_hs"}, {62'd0, aw_done, w_done}, 64'd3);
    wait_b(exp_resp, {tag, "_b"});
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    int cyc = 0;
    bit hs = 1'b0;
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!hs && cyc < 20) begin
      hs = ARREADY;
      tick();
      cyc++;
    end
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    cyc = 0;
    while (!RVALID && cyc < 20) begin
      tick();
      cyc++;
    end
    check(tag, {29'd0, RVALID, RRESP, RDATA}, {29'd0, 1'b1, exp_resp, exp_data});
    tick();
    RREADY = 1'b0;
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    b_cnt    = 0;
    ARESET  = 1'b0;
    AWADDR  = 32'd0; AWVALID = 1'b0;
    WDATA   = 32'd0; WSTRB   = 4'd0; WVALID = 1'b0;
    BREADY  = 1'b0;
    ARADDR  = 32'd0; ARVALID = 1'b0;
    RREADY  = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;

    // Reset state and release timing.
    tick();
    tick();
    check("rst_outputs", {23'd0, AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA}, 64'd0);
    ARESET = 1'b1;
    check("rel_ready_low", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    tick();
    check("rel_ready_high", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

    // Fill: data i+1 at 4*i, cycling through AW+W / AW first / W first.
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = (i % 5) + 1;
      case (i % 3)
        0:       do_write(32'(4*i), 32'(i+1), 4'hF, 0, 0, 2'b00, "fill_wr");
        1:       do_write(32'(4*i), 32'(i+1), 4'hF, 0, gap, 2'b00, "fill_wr");
        default: do_write(32'(4*i), 32'(i+1), 4'hF, gap, 0, 2'b00, "fill_wr");
      endcase
      exp_mem[i] = 32'(i+1);
    end
    check("fill_b_count", 64'(b_cnt), 64'd16);
    for (int i = 0; i < 16; i++) do_read(32'(4*i), exp_mem[i], 2'b00, "fill_rd");

    // Byte strobes.
    do_write(32'h0, 32'h11223344, 4'hF, 0, 0, 2'b00, "strb_full");
    do_write(32'h0, 32'hAABBCCDD, 4'b0101, 0, 0, 2'b00, "strb_part");
    exp_mem[0] = 32'h11BB33DD;
    do_read(32'h0, 32'h11BB33DD, 2'b00, "strb_rd");
    do_write(32'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, 2'b00, "strb_zero");
    do_read(32'h0, 32'h11BB33DD, 2'b00, "strb_zero_rd");

    // W three cycles ahead of AW, then B backpressure.
    AWADDR = 32'h0C; WDATA = 32'h33330003; WSTRB = 4'hF; WVALID = 1'b1;
    check("wfirst_wready", {63'd0, WREADY}, 64'd1);
    tick();
    WVALID = 1'b0;
    check("wfirst_after_w", {62'd0, WREADY, AWREADY}, 64'd1);
    tick();
    tick();
    AWVALID = 1'b1;
    check("wfirst_awready", {63'd0, AWREADY}, 64'd1);
    tick();
    AWVALID = 1'b0;
    check("wfirst_b_not_yet", {63'd0, BVALID}, 64'd0);
    tick();
    check("wfirst_b_rise", {61'd0, BVALID, BRESP}, 64'd4);
    exp_mem[3] = 32'h33330003;
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'h05050505;
    for (int c = 0; c < 5; c++) begin
      check("bp_b_hold", {59'd0, BVALID, BRESP, AWREADY, WREADY}, 64'h10);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bp_aw_after_b", {62'd0, BVALID, AWREADY}, 64'd1);
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b1;
    check("bp_wready", {63'd0, WREADY}, 64'd1);
    tick();
    WVALID = 1'b0;
    wait_b(2'b00, "bp_second_b");
    exp_mem[5] = 32'h05050505;
    do_read(32'h14, 32'h05050505, 2'b00, "bp_second_rd");

    // R backpressure.
    ARADDR = 32'h0C; ARVALID = 1'b1;
    check("rbp_arready", {63'd0, ARREADY}, 64'd1);
    tick();
    ARVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("rbp_hold", {30'd0, RVALID, ARREADY, RDATA}, {30'd0, 1'b1, 1'b0, 32'h33330003});
      tick();
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rbp_done", {30'd0, RVALID, ARREADY, RDATA}, {30'd0, 1'b0, 1'b1, 32'h33330003});

    // Out of range.
    do_write(32'h40, 32'h0000DEAD, 4'hF, 0, 0, 2'b10, "oor_wr");
    for (int i = 0; i < 16; i++) do_read(32'(4*i), exp_mem[i], 2'b00, "oor_regs");
    do_read(32'h40, 32'h0, 2'b10, "oor_rd");

    // Read on the commit edge returns the old value; a later read the new.
    old_v = exp_mem[7];
    AWADDR = 32'h1C; WDATA = 32'h77777777; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h1C; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    check("same_edge_rd", {30'd0, RVALID, BVALID, RDATA}, {30'd0, 1'b1, 1'b1, old_v});
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    exp_mem[7] = 32'h77777777;
    do_read(32'h1C, 32'h77777777, 2'b00, "after_commit_rd");

    // Reset with both responses pending.
    AWADDR = 32'h24; WDATA = 32'h99; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h08; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tick();
    check("midrst_pending", {30'd0, BVALID, RVALID, RDATA}, {30'd0, 1'b1, 1'b1, exp_mem[2]});
    #1;
    ARESET = 1'b0;
    #1;
    check("midrst_async", {23'd0, AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA}, 64'd0);
    tick();
    ARESET = 1'b1;
    check("midrst_rel_low", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    tick();
    check("midrst_rel_high", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;
    do_read(32'h00, 32'h0, 2'b00, "midrst_rd0");
    do_read(32'h08, 32'h0, 2'b00, "midrst_rd2");
    do_read(32'h24, 32'h0, 2'b00, "midrst_rd9");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
